// File: rtl/invalidate_broadcast_unit.sv
// -----------------------------------------------------------------------------
// invalidate_broadcast_unit
//
// Bus-side responder for the snoopy invalidate protocol. The command issued by
// the cache that currently holds the bus grant is latched and broadcast to the
// snoopy controllers of every other cache. Their acknowledgements are collected
// in a sticky mask, and once every cache has acknowledged, a single
// cpuIsInvalidated is returned to the issuing cache. The unit never interprets
// the command beyond NONE / not-NONE.
//
// Ports
//   clock                in   rising-edge clock
//   reset                in   asynchronous, active-high reset
//   ownerIndex           in   index of the granted cache (from the arbiter)
//   cpuCommandIn         in   command from the granted cache, NONE = idle
//   cpuIsInvalidated     out  all other caches have acknowledged (registered)
//   snoopyCommandOut     out  per-cache broadcast command, slice i = cache i
//   snoopyIsInvalidated  in   per-cache acknowledgement
//   timeoutError         out  acknowledgement timeout flag (registered)
//
// Command encoding: NONE=0, BUS_READ=1, BUS_READ_EXCLUSIVE=2, BUS_INVALIDATE=3.
//
// Optional feature (macro INVALIDATE_BROADCAST_TIMEOUT_EN):
//   defined   - BROADCAST gives up after TIMEOUT_CYCLES cycles without a full
//               set of acknowledgements, enters DONE and raises timeoutError
//               until the next transaction starts.
//   undefined - BROADCAST waits indefinitely and timeoutError is tied to 0.
// -----------------------------------------------------------------------------
module invalidate_broadcast_unit #(
    parameter int NUMBER_OF_CACHES = 4,
    parameter int INDEX_WIDTH      = 2,
    parameter int COMMAND_WIDTH    = 2,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [INDEX_WIDTH-1:0]                    ownerIndex,
    input  logic [COMMAND_WIDTH-1:0]                  cpuCommandIn,
    output logic                                      cpuIsInvalidated,
    output logic [NUMBER_OF_CACHES*COMMAND_WIDTH-1:0] snoopyCommandOut,
    input  logic [NUMBER_OF_CACHES-1:0]               snoopyIsInvalidated,
    output logic                                      timeoutError
);

    localparam logic [COMMAND_WIDTH-1:0] CMD_NONE = '0;
    localparam int CMD_BUS_W = NUMBER_OF_CACHES * COMMAND_WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BROADCAST = 2'd1,
        DONE      = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t                        state_q;
    logic [COMMAND_WIDTH-1:0]      cmd_q;        // latched command
    logic [INDEX_WIDTH-1:0]        owner_q;      // latched owner index
    logic [NUMBER_OF_CACHES-1:0]   ack_mask_q;   // sticky acknowledgements
    logic                          cpu_inv_q;
    logic [CMD_BUS_W-1:0]          snoop_cmd_q;

`ifdef INVALIDATE_BROADCAST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]              count_q;      // BROADCAST cycles elapsed
    logic                          timeout_q;
`endif

    // -------------------------------------------------------------------------
    // Next-state helpers
    // -------------------------------------------------------------------------
    logic [NUMBER_OF_CACHES-1:0]   preset_mask_d; // owner bit only
    logic [CMD_BUS_W-1:0]          bcast_cmd_d;   // latched command to all but owner
    logic                          ack_all_d;     // includes this cycle's acks

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path can leave it unassigned and
        // infer a latch.
        preset_mask_d = '0;
        bcast_cmd_d   = '0;
        for (int i = 0; i < NUMBER_OF_CACHES; i++) begin
            // An out-of-range owner matches no slot: no bit is preset and
            // every cache receives the broadcast.
            if (int'(ownerIndex) == i) begin
                preset_mask_d[i] = 1'b1;
            end
            if (int'(owner_q) != i) begin
                bcast_cmd_d[i*COMMAND_WIDTH +: COMMAND_WIDTH] = cmd_q;
            end
        end
        ack_all_d = &(ack_mask_q | snoopyIsInvalidated);
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: every register that is observable or steers control is
            // reset here, including the latched command and ack mask, so an
            // in-flight transaction is discarded cleanly.
            state_q     <= IDLE;
            cmd_q       <= CMD_NONE;
            owner_q     <= '0;
            ack_mask_q  <= '0;
            cpu_inv_q   <= 1'b0;
            snoop_cmd_q <= '0;
`ifdef INVALIDATE_BROADCAST_TIMEOUT_EN
            count_q     <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            unique case (state_q)
                IDLE: begin
                    cpu_inv_q   <= 1'b0;
                    snoop_cmd_q <= '0;
                    if (cpuCommandIn != CMD_NONE) begin
                        cmd_q      <= cpuCommandIn;
                        owner_q    <= ownerIndex;
                        ack_mask_q <= preset_mask_d;
                        state_q    <= BROADCAST;
`ifdef INVALIDATE_BROADCAST_TIMEOUT_EN
                        count_q    <= '0;
                        timeout_q  <= 1'b0;
`endif
                    end
                end

                BROADCAST: begin
                    // Inputs cpuCommandIn/ownerIndex are deliberately not
                    // looked at here; the latched copies drive the broadcast.
                    ack_mask_q <= ack_mask_q | snoopyIsInvalidated;
                    if (ack_all_d) begin
                        state_q     <= DONE;
                        cpu_inv_q   <= 1'b1;
                        snoop_cmd_q <= '0;
`ifdef INVALIDATE_BROADCAST_TIMEOUT_EN
                    end else if (count_q == CNT_LAST) begin
                        state_q     <= DONE;
                        cpu_inv_q   <= 1'b1;
                        snoop_cmd_q <= '0;
                        timeout_q   <= 1'b1;
                    end else begin
                        count_q     <= count_q + 1'b1;
                        snoop_cmd_q <= bcast_cmd_d;
                    end
`else
                    end else begin
                        snoop_cmd_q <= bcast_cmd_d;
                    end
`endif
                end

                DONE: begin
                    snoop_cmd_q <= '0;
                    if (cpuCommandIn == CMD_NONE) begin
                        state_q   <= IDLE;
                        cpu_inv_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    cpu_inv_q   <= 1'b0;
                    snoop_cmd_q <= '0;
                end
            endcase
        end
    end

    assign cpuIsInvalidated = cpu_inv_q;
    assign snoopyCommandOut = snoop_cmd_q;

`ifdef INVALIDATE_BROADCAST_TIMEOUT_EN
    assign timeoutError = timeout_q;
`else
    assign timeoutError = 1'b0;
`endif

endmodule

// File: tb/tb_invalidate_broadcast_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for invalidate_broadcast_unit.
// A transaction-level reference model advances on every clock edge and a
// compare process checks all DUT outputs against it on every falling edge.
// Directed sequences add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_invalidate_broadcast_unit;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 2;
    localparam int TO = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [IW-1:0]   owner_index;
    logic [CW-1:0]   cpu_cmd;
    logic            cpu_inv;
    logic [N*CW-1:0] snoop_cmd;
    logic [N-1:0]    snoop_ack;
    logic            timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    invalidate_broadcast_unit #(
        .NUMBER_OF_CACHES (N),
        .INDEX_WIDTH      (IW),
        .COMMAND_WIDTH    (CW),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .ownerIndex          (owner_index),
        .cpuCommandIn        (cpu_cmd),
        .cpuIsInvalidated    (cpu_inv),
        .snoopyCommandOut    (snoop_cmd),
        .snoopyIsInvalidated (snoop_ack),
        .timeoutError        (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: one open transaction at a time.
    //   busy     - a command has been accepted and not yet released
    //   finished - every cache (or the timeout) has completed it
    //   show     - the broadcast is currently visible on the snoop bus
    // -------------------------------------------------------------------------
    bit m_busy = 0, m_finished = 0, m_show = 0, m_cpu = 0, m_err = 0;
    int m_cmd = 0, m_owner = 0, m_cycles = 0;
    bit m_acked [N];

    function automatic logic [N*CW-1:0] exp_snoop();
        logic [N*CW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (m_show && i != m_owner) v[i*CW +: CW] = CW'(m_cmd);
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_finished = 0; m_show = 0; m_cpu = 0; m_err = 0;
        m_cmd = 0; m_owner = 0; m_cycles = 0;
        for (int i = 0; i < N; i++) m_acked[i] = 0;
    endtask

    task automatic model_step();
        bit all_in;
        if (!m_busy) begin
            m_cpu  = 0;
            m_show = 0;
            if (cpu_cmd != 0) begin
                m_busy = 1; m_finished = 0; m_cycles = 0; m_err = 0;
                m_cmd = int'(cpu_cmd); m_owner = int'(owner_index);
                for (int i = 0; i < N; i++) m_acked[i] = (i == m_owner);
            end
        end else if (!m_finished) begin
            m_cycles++;
            all_in = 1;
            for (int i = 0; i < N; i++) begin
                if (snoop_ack[i]) m_acked[i] = 1;
                if (!m_acked[i]) all_in = 0;
            end
            if (all_in) begin
                m_finished = 1; m_cpu = 1; m_show = 0;
`ifdef INVALIDATE_BROADCAST_TIMEOUT_EN
            end else if (m_cycles == TO) begin
                m_finished = 1; m_cpu = 1; m_show = 0; m_err = 1;
`endif
            end else begin
                m_show = 1;
            end
        end else begin
            m_show = 0;
            if (cpu_cmd == 0) begin
                m_busy = 0; m_cpu = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // Compare process: outputs are registered, so the falling edge is stable.
    initial begin
        forever begin
            @(negedge clock);
            check("cmp cpuIsInvalidated", 32'(cpu_inv), 32'(m_cpu));
            check("cmp snoopyCommandOut", 32'(snoop_cmd), 32'(exp_snoop()));
            check("cmp timeoutError", 32'(timeout_err), 32'(m_err));
        end
    end

    // -------------------------------------------------------------------------
    // Directed and random stimulus (inputs change on falling edges)
    // -------------------------------------------------------------------------
    logic [N-1:0] pat [6];

    initial begin
        reset = 1'b1; owner_index = '0; cpu_cmd = '0; snoop_ack = '0;
        repeat (2) @(negedge clock);
        check("reset cpuIsInvalidated", 32'(cpu_inv), 32'd0);
        check("reset snoopyCommandOut", 32'(snoop_cmd), 32'd0);
        check("reset timeoutError", 32'(timeout_err), 32'd0);
        reset = 1'b0;

        // --- owner 0, BUS_INVALIDATE, all acks in the first visible cycle ---
        @(negedge clock); owner_index = 2'd0; cpu_cmd = 2'd3;
        @(negedge clock);                                     // after edge 0
        check("t1 snoop after edge0", 32'(snoop_cmd), 32'h00);
        @(negedge clock);                                     // after edge 1
        check("t1 snoop after edge1", 32'(snoop_cmd), 32'hFC);
        check("t1 model snoop", 32'(exp_snoop()), 32'hFC);
        check("t1 cpu after edge1", 32'(cpu_inv), 32'd0);
        snoop_ack = '1;
        @(negedge clock);                                     // after edge 2
        check("t1 cpu after edge2", 32'(cpu_inv), 32'd1);
        check("t1 snoop in done", 32'(snoop_cmd), 32'h00);
        snoop_ack = '0; cpu_cmd = 2'd0;
        @(negedge clock);
        check("t1 cpu after release", 32'(cpu_inv), 32'd0);

        // --- owner 2, BUS_READ_EXCLUSIVE, single-cycle ack pulses ---
        pat = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h8};
        owner_index = 2'd2; cpu_cmd = 2'd2;
        @(negedge clock);                                     // after edge 0
        for (int n = 0; n < 6; n++) begin
            if (n == 1) check("t2 snoop broadcast", 32'(snoop_cmd), 32'h8A);
            if (n == 5) check("t2 cpu before last ack", 32'(cpu_inv), 32'd0);
            snoop_ack = pat[n];
            @(negedge clock);
        end
        check("t2 cpu after last ack", 32'(cpu_inv), 32'd1);
        check("t2 model cpu", 32'(m_cpu), 32'd1);
        snoop_ack = '0;

        // --- command held in DONE, release, immediate restart ---
        repeat (5) begin
            @(negedge clock);
            check("t3 cpu held", 32'(cpu_inv), 32'd1);
            check("t3 snoop none", 32'(snoop_cmd), 32'h00);
        end
        cpu_cmd = 2'd0;
        @(negedge clock);
        check("t3 cpu idle", 32'(cpu_inv), 32'd0);
        owner_index = 2'd1; cpu_cmd = 2'd1;
        @(negedge clock);                                     // after edge 0
        owner_index = 2'd3; cpu_cmd = 2'd2;                   // must be ignored
        @(negedge clock);                                     // after edge 1
        check("t4 snoop keeps original", 32'(snoop_cmd), 32'h51);
        snoop_ack = '1;
        @(negedge clock);
        check("t4 cpu done", 32'(cpu_inv), 32'd1);
        snoop_ack = '0; cpu_cmd = 2'd0;
        @(negedge clock);

        // --- asynchronous reset two cycles into BROADCAST ---
        owner_index = 2'd0; cpu_cmd = 2'd3;
        repeat (3) @(negedge clock);                          // after edge 2
        check("t5 snoop before reset", 32'(snoop_cmd), 32'hFC);
        #2 reset = 1'b1; cpu_cmd = 2'd0;
        #1;
        check("t5 async cpu", 32'(cpu_inv), 32'd0);
        check("t5 async snoop", 32'(snoop_cmd), 32'h00);
        check("t5 async timeout", 32'(timeout_err), 32'd0);
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        check("t5 discarded", 32'(snoop_cmd), 32'h00);

        // --- cache 3 never acknowledges ---
        owner_index = 2'd0; cpu_cmd = 2'd3; snoop_ack = 4'b0110;
        repeat (16) @(negedge clock);                         // after edge 15
        check("t6 cpu before limit", 32'(cpu_inv), 32'd0);
        @(negedge clock);                                     // after edge 16
`ifdef INVALIDATE_BROADCAST_TIMEOUT_EN
        check("t6 cpu at timeout", 32'(cpu_inv), 32'd1);
        check("t6 timeoutError", 32'(timeout_err), 32'd1);
        repeat (4) @(negedge clock);
        check("t6 error held", 32'(timeout_err), 32'd1);
`else
        check("t6 cpu still waiting", 32'(cpu_inv), 32'd0);
        check("t6 no timeoutError", 32'(timeout_err), 32'd0);
        repeat (4) @(negedge clock);
        check("t6 still broadcasting", 32'(snoop_cmd), 32'hFC);
`endif
        snoop_ack = 4'b1000;
        @(negedge clock);
        check("t6 done", 32'(cpu_inv), 32'd1);
        snoop_ack = '0; cpu_cmd = 2'd0;
        repeat (2) @(negedge clock);

        // --- randomized traffic against the model ---
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            cpu_cmd     = ($urandom_range(0, 2) == 0) ? 2'd0 : CW'($urandom_range(1, 3));
            owner_index = IW'($urandom);
            for (int i = 0; i < N; i++) snoop_ack[i] = ($urandom_range(0, 99) < 40);
        end
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
